// File: rtl/gray_counter_pkg.sv
// Shared constants for the Gray counter and its gray2bin decode stage.
package gray_counter_pkg;

    localparam int unsigned GrayWidth = 4;

    // Terminal binary count values at the default width.
    localparam logic [GrayWidth-1:0] BinOnes = '1;
    localparam logic [GrayWidth-1:0] BinZero = '0;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray encoder.
module bin2gray
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = GrayWidth
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder for the downstream stage.
module gray2bin
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = GrayWidth
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with synchronous load, terminal-count flag and wrap pulse.
module gray_counter
    import gray_counter_pkg::*;
#(
    parameter int unsigned WIDTH = GrayWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TopBin  = {WIDTH{BinOnes[0]}};
    localparam logic [WIDTH-1:0] ZeroBin = {WIDTH{BinZero[0]}};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q;

    // Inline prefix-XOR decode of the load value.
    always_comb begin
        load_bin = '0;
        load_bin[WIDTH-1] = load_gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_gray[i];
        end
    end

    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            bin_d = up ? bin_q + 1'b1 : bin_q - 1'b1;
        end
    end

    // Gated by rst_n so tc stays low while reset is held.
    assign tc = rst_n & en & ~load &
                ((up & (bin_q == TopBin)) | (~up & (bin_q == ZeroBin)));

    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin (bin_d),
        .gray(gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= tc;
        end
    end

    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter chained into gray2bin.
module tb_gray_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_gray;
    logic [3:0] gray;
    logic       tc;
    logic       wrap;
    logic [3:0] bin;

    int checks = 0;
    int errors = 0;

    gray_counter #(
        .WIDTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_gray(load_gray),
        .gray     (gray),
        .tc       (tc),
        .wrap     (wrap)
    );

    gray2bin #(
        .WIDTH(4)
    ) u_g2b (
        .gray(gray),
        .bin (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        up = 1'b0;
        load = 1'b0;
        load_gray = 4'b0000;
        #2;
        checks++;
        if (gray !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gray: got %b expected 0000", gray);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: got %b expected 0", tc);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap: got %b expected 0", wrap);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
    endtask

    task automatic test_up_count();
        logic [3:0] exp_up [16];
        logic [3:0] prev;
        exp_up = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        prev = 4'b0000;
        en = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (tc !== (i == 15)) begin
                errors++;
                $display("FAIL up_tc[%0d]: got %b expected %b", i, tc, (i == 15));
            end
            @(posedge clk);
            #1;
            checks++;
            if (gray !== exp_up[i]) begin
                errors++;
                $display("FAIL up_gray[%0d]: got %b expected %b", i, gray, exp_up[i]);
            end
            checks++;
            if (wrap !== (i == 15)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, (i == 15));
            end
            checks++;
            if ($countones(gray ^ prev) != 1) begin
                errors++;
                $display("FAIL up_onebit[%0d]: got %b after %b expected one bit change",
                         i, gray, prev);
            end
            checks++;
            if (bin !== 4'((i + 1) % 16)) begin
                errors++;
                $display("FAIL up_bin[%0d]: got %0d expected %0d", i, bin, (i + 1) % 16);
            end
            prev = gray;
            @(negedge clk);
        end
    endtask

    task automatic test_down_wrap();
        en = 1'b1;
        up = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc_before: got %b expected 1", tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b1000) begin
            errors++;
            $display("FAIL down_gray_wrap: got %b expected 1000", gray);
        end
        checks++;
        if (wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: got %b expected 1", wrap);
        end
        @(negedge clk);
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL down_tc_after: got %b expected 0", tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b1001) begin
            errors++;
            $display("FAIL down_gray_next: got %b expected 1001", gray);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap_clear: got %b expected 0", wrap);
        end
        @(negedge clk);
    endtask

    task automatic test_load_priority();
        // From 1001 (bin 14), one up-step gives 1000 (bin 15).
        up = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b1000) begin
            errors++;
            $display("FAIL load_setup: got %b expected 1000", gray);
        end
        @(negedge clk);
        load = 1'b1;
        load_gray = 4'b1100;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL load_tc: got %b expected 0", tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b1100) begin
            errors++;
            $display("FAIL load_gray: got %b expected 1100", gray);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_wrap: got %b expected 0", wrap);
        end
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b1101) begin
            errors++;
            $display("FAIL load_step: got %b expected 1101", gray);
        end
        @(negedge clk);
        // Loading the wrap target (0000) from bin 15 must not flag a wrap.
        load = 1'b1;
        load_gray = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        load_gray = 4'b0000;
        #1;
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL load_target_tc: got %b expected 0", tc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_target: got gray=%b wrap=%b expected gray=0000 wrap=0",
                     gray, wrap);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_hold_and_reset();
        load = 1'b1;
        load_gray = 4'b0110;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = ~up;
            #1;
            checks++;
            if (tc !== 1'b0) begin
                errors++;
                $display("FAIL hold_tc[%0d]: got %b expected 0", i, tc);
            end
            @(posedge clk);
            #1;
            checks++;
            if (gray !== 4'b0110 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got gray=%b wrap=%b expected gray=0110 wrap=0",
                         i, gray, wrap);
            end
            @(negedge clk);
        end
        en = 1'b1;
        up = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gray !== 4'b0000 || wrap !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got gray=%b wrap=%b tc=%b expected 0000 0 0",
                     gray, wrap, tc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        up = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gray !== 4'b0001) begin
            errors++;
            $display("FAIL after_reset_step: got %b expected 0001", gray);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_load_priority();
        test_hold_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, the count width in bits; all requirements below are stated for WIDTH=4.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port en, input, 1, count enable.
REQ-005 The module SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-006 The module SHALL have port load, input, 1, synchronous load strobe.
REQ-007 The module SHALL have port load_gray, input, WIDTH, the Gray-coded value to load.
REQ-008 The module SHALL have port gray, output, WIDTH, the registered Gray-coded count, feeding the downstream gray2bin stage.
REQ-009 The module SHALL have port tc, output, 1, terminal count: the next enabled step wraps.
REQ-010 The module SHALL have port wrap, output, 1, registered one-cycle pulse marking a wrapped value on gray.

Function
REQ-011 The block SHALL hold the count as a WIDTH-bit binary register bin_q and SHALL drive gray from a register loaded with bin2gray(next bin_q), so gray has no combinational path from any input.
REQ-012 Per rising edge, the block SHALL apply this priority: load=1 -> bin_q <= gray-to-binary(load_gray); else en=1 and up=1 -> bin_q+1 mod 16; else en=1 and up=0 -> bin_q-1 mod 16; else hold.
REQ-013 The latency SHALL be one cycle: a load or step sampled at edge N SHALL appear on gray immediately after edge N.
REQ-014 Each enabled step SHALL change exactly one bit of gray, including both wrap-around transitions (1000<->0000).
REQ-015 The block SHALL assert tc combinationally when en=1, load=0, and either (up=1 and bin_q=15) or (up=0 and bin_q=0); otherwise tc SHALL be 0.
REQ-016 The block SHALL set wrap to 1 for exactly the one cycle following an edge at which tc=1, and to 0 otherwise.
REQ-017 When load and en are asserted together, load SHALL win, and neither tc nor wrap SHALL assert, even if the loaded value equals the wrap target.
REQ-018 When en=0, gray SHALL hold; toggling up while en=0 SHALL have no effect on gray, tc, or wrap.
REQ-019 Changing up between consecutive enabled cycles SHALL take effect on the next edge with no dead cycle.

Reset
REQ-020 When rst_n=0, the block SHALL immediately and asynchronously force bin_q=0, gray=0000, and wrap=0; tc SHALL be 0 while reset is asserted.
REQ-021 A reset asserted mid-count SHALL discard the count; after rst_n rises, the first enabled up-step SHALL produce gray=0001.
REQ-022 Reset deassertion SHALL be synchronized externally; the block SHALL NOT contain its own reset synchronizer.

Structure
REQ-023 The shared package SHALL hold the WIDTH default constant and the terminal binary values (all-ones, zero), so that gray_counter and gray2bin share a single width definition.
REQ-024 The Gray encoding SHALL be placed in one combinational sub-module, bin2gray (gray = bin ^ (bin >> 1)), instantiated once on the next-state path.
REQ-025 The load path's gray-to-binary conversion SHALL be an inline prefix-XOR and SHALL NOT instantiate gray2bin.

Verification
REQ-026 The bench SHALL cover reset: rst_n=0 -> gray=0000, tc=0, wrap=0, with no clock edge required.
REQ-027 The bench SHALL cover a full up-count: en=1, up=1 for 16 cycles -> gray 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; tc=1 while gray=1000; wrap=1 with the final 0000; a one-bit change at every step.
REQ-028 The bench SHALL cover down-count wrap: from 0000, en=1, up=0 -> tc=1 before the edge; next gray=1000 with wrap=1; then 1001.
REQ-029 The bench SHALL cover load priority: gray=1000, up=1, en=1, load=1, load_gray=1100 -> gray=1100, tc=0, wrap=0; next enabled up-step -> gray=1101.
REQ-030 The bench SHALL cover hold and mid-count reset: gray=0110 with en=0 and up toggled for 5 cycles -> gray stays 0110; pulsing rst_n low between edges -> gray=0000 at once; first enabled up-step after release -> gray=0001.
REQ-031 The bench SHALL check a direct chain into gray2bin: the 16-step up-count of REQ-027 SHALL yield bin values 1..15, 0 in order.
